// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus responder: FSM states, bus bit positions, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bus_pkg;

  localparam int ADDR_W     = 10;
  localparam int WORD_W     = 12;
  localparam int HALF_W     = WORD_W / 2;

  // Bit positions of the control flags inside the CPU bus word
  localparam int RW_BIT     = 11;
  localparam int COMMIT_BIT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

endpackage

// File: rtl/resp_mem_array.sv
// Word-wide storage with one synchronous write port and one registered read port.
// Latency: 1 cycle read; a same-edge write to the read address is forwarded to the read data.
// Backpressure: none; read data holds its value until the next enabled read.
module resp_mem_array #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_dat,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_dat
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rd_dat;

  // Array contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  // Read register: cleared by reset, updates only on an enabled read, write data wins on a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_dat <= '0;
    end else if (i_rd_en) begin
      if (i_wr_en && (i_wr_addr == i_rd_addr)) r_rd_dat <= i_wr_dat;
      else                                     r_rd_dat <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/mem_bus_responder.sv
// CPU bus responder: single-cycle reads, three-cycle address/low/high write protocol, sticky protocol error.
// Latency: 1 cycle from a read request to mem_result; a write lands on the edge of the high-half commit.
// Backpressure: none; every bus cycle is consumed. Optional rd/wr counters under MEM_BUS_RESPONDER_STATS_EN.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int WORD_W = mem_bus_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RW_BIT:0]   bus_in,
  output logic [WORD_W-1:0] mem_result,
  output logic              busy,
  output logic              proto_err
`ifdef MEM_BUS_RESPONDER_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int HALF_W = WORD_W / 2;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_rw;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_ad;
  logic                w_rd_en;
  logic                w_wr_en;
  logic                w_lat_addr;
  logic                w_cap_lo;
  logic                w_err_set;
  logic [ADDR_W-1:0]   r_addr;
  logic [HALF_W-1:0]   r_lo;
  logic                r_proto_err;
  logic [WORD_W-1:0]   w_wr_dat;

  assign w_rw     = bus_in[RW_BIT];
  assign w_commit = bus_in[COMMIT_BIT];
  assign w_ad     = bus_in[ADDR_W-1:0];
  assign w_wr_dat = {w_ad[HALF_W-1:0], r_lo};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Bus decode: next state plus one-cycle action strobes
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_lat_addr   = 1'b0;
    w_cap_lo     = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_commit) begin
          // A commit with no open write is dropped and flagged
          w_err_set = 1'b1;
        end else if (w_rw) begin
          w_lat_addr   = 1'b1;
          w_next_state = WR_LO;
        end else begin
          w_rd_en = 1'b1;
        end
      end
      WR_LO, WR_HI: begin
        if (w_commit) begin
          if (r_state == WR_LO) begin
            w_cap_lo     = 1'b1;
            w_next_state = WR_HI;
          end else begin
            w_wr_en      = 1'b1;
            w_next_state = IDLE;
          end
        end else if (w_rw) begin
          // New address restarts the write cleanly, no error
          w_lat_addr   = 1'b1;
          w_next_state = WR_LO;
        end else begin
          // Read in the middle of a write: abandon the write, still serve the read
          w_rd_en      = 1'b1;
          w_err_set    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Write context (address, low half) and the sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_lo        <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_lat_addr) begin
        r_addr <= w_ad;
        r_lo   <= '0;
      end
      if (w_cap_lo)  r_lo        <= w_ad[HALF_W-1:0];
      if (w_err_set) r_proto_err <= 1'b1;
    end
  end

  resp_mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_addr),
    .i_wr_dat  (w_wr_dat),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_ad),
    .o_rd_dat  (mem_result)
  );

  assign busy      = (r_state != IDLE);
  assign proto_err = r_proto_err;

`ifdef MEM_BUS_RESPONDER_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  // Saturating counters of serviced reads and completed writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_en && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
      if (w_wr_en && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: reads, writes, restart, aborts, stray commits, async reset.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: n/a. Counter checks are included when MEM_BUS_RESPONDER_STATS_EN is defined.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bus_in;
  logic [11:0] mem_result;
  logic        busy;
  logic        proto_err;
`ifdef MEM_BUS_RESPONDER_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .mem_result (mem_result),
    .busy       (busy),
    .proto_err  (proto_err)
`ifdef MEM_BUS_RESPONDER_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] bv(input logic rw, input logic c, input logic [9:0] ad);
    return {rw, c, ad};
  endfunction

  // One bus cycle: drive on the falling edge, settle just after the rising edge
  task automatic step(input logic [11:0] v);
    @(negedge clk);
    bus_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [9:0] a, input logic [11:0] w);
    step(bv(1'b1, 1'b0, a));
    step(bv(1'b0, 1'b1, {4'b0, w[5:0]}));
    step(bv(1'b0, 1'b1, {4'b0, w[11:6]}));
  endtask

  initial begin
    rst    = 1'b1;
    bus_in = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_result", mem_result, 12'h000);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_proto_err",  proto_err,  1'b0);

    // Preload 0x005 = 0xABC (low 0x3C, high 0x2A), first cycle out of reset opens the write
    @(negedge clk);
    rst    = 1'b0;
    bus_in = bv(1'b1, 1'b0, 10'h005);
    @(posedge clk);
    #1;
    chk("pre_open_busy",   busy,       1'b1);
    chk("pre_open_hold",   mem_result, 12'h000);
    step(bv(1'b0, 1'b1, 10'h03C));
    chk("pre_lo_busy",     busy,       1'b1);
    step(bv(1'b0, 1'b1, 10'h02A));
    chk("pre_hi_idle",     busy,       1'b0);
    step(bv(1'b0, 1'b0, 10'h005));
    chk("read_005",        mem_result, 12'hABC);

    // Write 0x010: low 0x15, high 0x2A -> 0xA95
    step(bv(1'b1, 1'b0, 10'h010));
    chk("w010_busy1",      busy,       1'b1);
    chk("w010_hold",       mem_result, 12'hABC);
    step(bv(1'b0, 1'b1, 10'h015));
    chk("w010_busy2",      busy,       1'b1);
    step(bv(1'b0, 1'b1, 10'h02A));
    chk("w010_done",       busy,       1'b0);
    step(bv(1'b0, 1'b0, 10'h010));
    chk("read_010",        mem_result, 12'hA95);
    chk("w010_no_err",     proto_err,  1'b0);

    // Restart: open 0x020, capture a low half, then re-open at 0x021
    wr_word(10'h020, 12'h081);
    step(bv(1'b0, 1'b0, 10'h020));
    chk("read_020",        mem_result, 12'h081);
    step(bv(1'b1, 1'b0, 10'h020));
    step(bv(1'b0, 1'b1, 10'h011));
    step(bv(1'b1, 1'b0, 10'h021));
    chk("restart_busy",    busy,       1'b1);
    step(bv(1'b0, 1'b1, 10'h005));
    step(bv(1'b0, 1'b1, 10'h006));
    step(bv(1'b0, 1'b0, 10'h021));
    chk("read_021",        mem_result, 12'h185);
    chk("restart_no_err",  proto_err,  1'b0);
    step(bv(1'b0, 1'b0, 10'h020));
    chk("restart_020_kept", mem_result, 12'h081);

    // Stray commit in IDLE against the top address
    wr_word(10'h3FF, 12'h03F);
    step(bv(1'b0, 1'b0, 10'h005));
    chk("no_alias_005",    mem_result, 12'hABC);
    step(bv(1'b0, 1'b1, 10'h3FF));
    chk("stray_hold",      mem_result, 12'hABC);
    chk("stray_err",       proto_err,  1'b1);
    chk("stray_idle",      busy,       1'b0);
    step(bv(1'b0, 1'b0, 10'h3FF));
    chk("read_3ff",        mem_result, 12'h03F);

    // Asynchronous reset in the middle of a write to 0x3FF
    step(bv(1'b1, 1'b0, 10'h3FF));
    step(bv(1'b0, 1'b1, 10'h02A));
    chk("midrst_busy_pre", busy,       1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_result",   mem_result, 12'h000);
    chk("midrst_busy",     busy,       1'b0);
    chk("midrst_err",      proto_err,  1'b0);
    bus_in = bv(1'b0, 1'b0, 10'h3FF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_3ff_kept", mem_result, 12'h03F);
    chk("midrst_err_after", proto_err, 1'b0);

    // Read during WR_HI aborts the write to 0x020
    step(bv(1'b1, 1'b0, 10'h020));
    step(bv(1'b0, 1'b1, 10'h01F));
    step(bv(1'b0, 1'b0, 10'h020));
    chk("abort_read",      mem_result, 12'h081);
    chk("abort_err",       proto_err,  1'b1);
    chk("abort_idle",      busy,       1'b0);
    step(bv(1'b0, 1'b0, 10'h010));
    chk("abort_other",     mem_result, 12'hA95);
    chk("abort_err_sticky", proto_err, 1'b1);

`ifdef MEM_BUS_RESPONDER_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("st_rst_rd", rd_count, 16'd0);
    chk("st_rst_wr", wr_count, 16'd0);
    @(negedge clk);
    rst    = 1'b0;
    bus_in = bv(1'b1, 1'b0, 10'h030);
    @(posedge clk);
    #1;
    step(bv(1'b0, 1'b1, 10'h001));
    step(bv(1'b0, 1'b1, 10'h002));
    wr_word(10'h031, 12'h0C3);
    step(bv(1'b0, 1'b0, 10'h030));
    chk("st_read_030", mem_result, 12'h081);
    step(bv(1'b0, 1'b0, 10'h031));
    chk("st_read_031", mem_result, 12'h0C3);
    step(bv(1'b0, 1'b0, 10'h005));
    chk("st_rd_count", rd_count, 16'd3);
    chk("st_wr_count", wr_count, 16'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("st_clr_rd", rd_count, 16'd0);
    chk("st_clr_wr", wr_count, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning memory address width (depth = 2**ADDR_W words).
REQ-002 SHALL have parameter WORD_W, default 12, meaning memory word width; HALF_W = WORD_W/2 = 6.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bus_in  input  12  CPU bus output, packed {read_write[11], write_commit[10], addr_data[9:0]}.
REQ-006 SHALL have port mem_result  output  12  registered word returned to the CPU bus input.
REQ-007 SHALL have port busy  output  1  high while a write transaction is open (state != IDLE).
REQ-008 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-009 SHALL decode each cycle: rw=bus_in[11], commit=bus_in[10], ad=bus_in[9:0].
REQ-010 SHALL implement FSM states IDLE, WR_LO, WR_HI.
REQ-011 IDLE, rw=0, commit=0: SHALL register mem[ad] onto mem_result at the next edge (1-cycle read latency); state stays IDLE.
REQ-012 IDLE, rw=1, commit=0: SHALL latch ad as the write address and move to WR_LO; mem_result holds.
REQ-013 WR_LO, commit=1: SHALL capture ad[5:0] as the low half and move to WR_HI.
REQ-014 WR_HI, commit=1: SHALL write mem[addr] = {ad[5:0], low_half} and return to IDLE.
REQ-015 WR_LO or WR_HI, rw=1, commit=0: SHALL restart the write by latching the new address and moving to WR_LO, discarding any captured half; proto_err is not set.
REQ-016 WR_LO or WR_HI, rw=0, commit=0: SHALL abort the write without modifying memory, serve the read per REQ-011, return to IDLE and set proto_err.
REQ-017 IDLE, commit=1: SHALL ignore the cycle (no memory change, mem_result holds) and set proto_err.
REQ-018 A read of an address completed by a write on the immediately preceding edge SHALL return the new data.
REQ-019 Addresses SHALL use the full ADDR_W bits, with no wrap or aliasing inside the array.
REQ-020 mem_result SHALL change only on a serviced read.

Reset
REQ-021 On rst assertion, regardless of clock, the block SHALL force state=IDLE, mem_result=0, busy=0, proto_err=0, captured address and half cleared.
REQ-022 Memory array contents SHALL NOT be reset.
REQ-023 Reset asserted mid-write SHALL abandon the transaction with no memory write.
REQ-024 proto_err SHALL clear only on reset.

Configuration
REQ-025 With macro MEM_BUS_RESPONDER_STATS_EN defined, the block SHALL add outputs rd_count[15:0] and wr_count[15:0]:
  - rd_count increments per serviced read; wr_count per completed write.
  - Both saturate at 16'hFFFF and reset to 0.
REQ-026 Without MEM_BUS_RESPONDER_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package mem_bus_pkg SHALL hold:
  - the FSM state enum (IDLE, WR_LO, WR_HI);
  - bus bit-position constants (RW_BIT=11, COMMIT_BIT=10);
  - default widths ADDR_W, WORD_W, HALF_W.
REQ-028 Storage SHALL be one sub-module resp_mem_array:
  - synchronous write port, synchronous read port;
  - write-before-read on the same edge, satisfying REQ-018.

Verification
REQ-029 Reset, preload mem[0x005]=12'hABC, drive bus_in={0,0,10'h005} -> mem_result=12'hABC one edge later.
REQ-030 Drive {1,0,10'h010}, then {0,1,10'h015}, then {0,1,10'h02A}, then read 0x010 -> busy high for 2 cycles; mem_result=12'hA95; proto_err=0.
REQ-031 Drive {1,0,10'h020}, then {0,1,10'h01F}, then read 0x020 -> write aborted; mem[0x020] unchanged; proto_err=1; state IDLE.
REQ-032 In IDLE, drive {0,1,10'h3FF} -> no memory or mem_result change; proto_err=1.
REQ-033 Open a write to 0x3FF, capture the low half, assert rst asynchronously mid-cycle -> mem_result=0, busy=0 immediately; mem[0x3FF] unchanged.
REQ-034 With MEM_BUS_RESPONDER_STATS_EN defined, 3 reads + 2 writes -> rd_count=3, wr_count=2; after reset both read 0.
